decoupler: RTL

//  Width splitter: inverse of the pair-coupler in the merge pipeline.
//  - Accepts 2*P_WIDTH words {hi,lo} and emits P_WIDTH elements in order: lo, then hi.
//  - A lo of all zeros is the stream terminator. It is emitted alone and the hi half is discarded.
//  - Sits at the output of a wide merger, feeding narrower downstream stages or memory.

---
 rtl/decoupler_pkg.sv | 16 +
 rtl/decoupler_fifo.sv | 83 ++++++++
 rtl/decoupler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/decoupler_pkg.sv
// Shared definitions for the decoupler width splitter.
//  - FSM state encoding for the lo/hi split sequencer.
//  - Terminator element: an all-zero element. The package cannot depend on
//    the top-level width, so the constant is wide and is narrowed with a cast
//    where it is used.
package decoupler_pkg;

  // Split sequencer states.
  localparam logic S_LO = 1'b0;  // next element to emit is the lo half
  localparam logic S_HI = 1'b1;  // lo already emitted, hi still to emit

  // All-zero terminator. Narrow it with P_WIDTH'(TERM_ELEM).
  localparam int               TERM_MAX_W = 4096;
  localparam logic [TERM_MAX_W-1:0] TERM_ELEM  = '0;

endpackage

// File: rtl/decoupler_fifo.sv
// Synchronous first-word-fall-through FIFO used twice by the decoupler.
//  - The head entry is visible on o_data whenever o_empty is low. o_data is
//    forced to zero while the FIFO is empty, so it also reads zero after reset.
//  - o_full and o_empty are registered. They are computed from the next
//    occupancy, so they are correct in the cycle right after each edge.
//  - An enq while full and a deq while empty are ignored.
//  - o_count is the registered occupancy, 0..DEPTH.
// Ports:
//  i_clk, i_rst_n   clock; synchronous active-low reset (flushes the FIFO)
//  i_data, i_enq    write side
//  o_full           registered full flag
//  o_data, i_deq    read side (FWFT head, pop)
//  o_empty          registered empty flag
//  o_count          registered occupancy
module decoupler_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_enq,
  output logic                       o_full,
  output logic [WIDTH-1:0]           o_data,
  input  logic                       i_deq,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_enq;
  logic             do_deq;

  // Gating uses the registered flags only. A pop in the same cycle does not
  // make room for a push that was presented while full.
  assign do_enq = i_enq && !full_q;
  assign do_deq = i_deq && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(do_enq) - CW'(do_deq);
    if (do_enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_deq) rd_ptr_d = rd_ptr_q + AW'(1);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset. The pointers and count define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (do_enq) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_count = count_q;

endmodule

// File: rtl/decoupler.sv
// Width splitter: takes 2*P_WIDTH words {hi,lo} and emits P_WIDTH elements,
// lo first and then hi. A lo of all zeros is a stream terminator. It is
// emitted alone and its hi half is discarded.
//
// Handshake (both sides): a push (i_enq) is taken at a rising edge only when
// o_full was low before that edge. A pop (i_deq) is taken only when o_empty
// was low before that edge. Requests presented otherwise are ignored. Push and
// pop on the same cycle are independent.
//
// Ports:
//  i_clk, i_rst_n  clock; synchronous active-low reset (flushes everything)
//  i_data, i_enq   wide input word and push
//  o_full          input FIFO full (registered)
//  o_data, i_deq   head element of the output FIFO (FWFT) and pop
//  o_empty         output FIFO empty (registered)
module decoupler
  import decoupler_pkg::*;
#(
  parameter int P_WIDTH = 512,
  parameter int P_DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [2*P_WIDTH-1:0]   i_data,
  input  logic                   i_enq,
  output logic                   o_full,
  output logic [P_WIDTH-1:0]     o_data,
  input  logic                   i_deq,
  output logic                   o_empty
);

  localparam int CW = $clog2(P_DEPTH) + 1;
  localparam logic [P_WIDTH-1:0] TERM = P_WIDTH'(TERM_ELEM);

  logic [2*P_WIDTH-1:0] in_data;
  logic                 in_empty;
  logic                 in_deq;
  logic [CW-1:0]        in_count;
  logic                 out_full;
  logic [CW-1:0]        out_count;
  logic [CW:0]          out_level;
  logic                 out_room;
  logic                 advance;
  logic [P_WIDTH-1:0]   in_lo;
  logic [P_WIDTH-1:0]   in_hi;

  // Sequencer state, plus one registered element stage feeding out_fifo.
  // The stage gives the two-edge lo latency and keeps the mux off the
  // out_fifo write path.
  logic               state_q, state_d;
  logic               pipe_vld_q, pipe_vld_d;
  logic [P_WIDTH-1:0] pipe_data_q, pipe_data_d;

  decoupler_fifo #(.WIDTH(2*P_WIDTH), .DEPTH(P_DEPTH)) u_in_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (i_data),
    .i_enq   (i_enq),
    .o_full  (o_full),
    .o_data  (in_data),
    .i_deq   (in_deq),
    .o_empty (in_empty),
    .o_count (in_count)
  );

  decoupler_fifo #(.WIDTH(P_WIDTH), .DEPTH(P_DEPTH)) u_out_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_data  (pipe_data_q),
    .i_enq   (pipe_vld_q),
    .o_full  (out_full),
    .o_data  (o_data),
    .i_deq   (i_deq),
    .o_empty (o_empty),
    .o_count (out_count)
  );

  // The input occupancy is not needed. Only the empty flag gates the sequencer.
  logic unused_in_count;
  assign unused_in_count = ^in_count;

  assign in_lo = in_data[P_WIDTH-1:0];
  assign in_hi = in_data[2*P_WIDTH-1:P_WIDTH];

  // The element in the pipe stage has already been committed to out_fifo.
  // Count it as occupancy so that a new push can never overflow out_fifo,
  // even if the downstream side never pops.
  assign out_level = {1'b0, out_count} + {{CW{1'b0}}, pipe_vld_q};
  assign out_room  = !out_full && (out_level < (CW+1)'(P_DEPTH));
  assign advance   = !in_empty && out_room;

  always_comb begin
    state_d     = state_q;
    pipe_vld_d  = 1'b0;
    pipe_data_d = pipe_data_q;
    in_deq      = 1'b0;
    if (advance) begin
      pipe_vld_d = 1'b1;
      if (state_q == S_LO) begin
        pipe_data_d = in_lo;
        if (in_lo == TERM) begin
          // Terminator: emit it alone and drop the hi half.
          in_deq = 1'b1;
        end else begin
          // Keep the word at the head until its hi half is emitted.
          state_d = S_HI;
        end
      end else begin
        pipe_data_d = in_hi;
        in_deq      = 1'b1;
        state_d     = S_LO;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_LO;
      pipe_vld_q  <= 1'b0;
      pipe_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
    end
  end

endmodule
